// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed data memory.
// Handles one RISC-V load or store at a time; byte and halfword stores become
// read-modify-write sequences because the memory only takes full-word writes.
module load_store_unit #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                  r_state;
  // Latched request. Only the byte offset and the low halfword of the store
  // data are needed after acceptance; the word address lives in r_mem_addr
  // and full-word store data goes straight into r_mem_wdata.
  logic                    r_write;
  logic [2:0]              r_funct3;
  logic [1:0]              r_byte_off;
  logic [15:0]             r_wdata;
  // Registered outputs.
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_err;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic                    r_mem_we;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;

  logic                    w_illegal;
  logic                    w_misaligned;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;

  // Classify the incoming request as illegal or misaligned before acceptance.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (req_write) begin
      w_illegal = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
    end else begin
      w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
    case (req_funct3[1:0])
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  // Extract the addressed lane for loads and merge store data for SB/SH.
  always_comb begin
    w_shifted = mem_rdata >> {r_byte_off, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = r_byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_load_data = {24'h0, w_byte};
      F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   w_load_data = {16'h0, w_half};
      default: w_load_data = mem_rdata;
    endcase
    w_merged = mem_rdata;
    if (r_funct3 == F3_B) begin
      w_merged[{r_byte_off, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_byte_off[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  // Request FSM; all memory and response outputs are registered here.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= 3'b000;
      r_byte_off   <= 2'b00;
      r_wdata      <= 16'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      // Pulses default low and are raised only on the edge entering WR/RESP.
      r_resp_valid <= 1'b0;
      r_mem_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_funct3   <= req_funct3;
            r_byte_off <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            r_mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (w_illegal || w_misaligned) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= S_RESP;
            end else if (req_write && req_funct3 == F3_W) begin
              r_mem_wdata <= req_wdata;
              r_mem_we    <= 1'b1;
              r_state     <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (r_write) begin
            r_mem_wdata <= w_merged;
            r_mem_we    <= 1'b1;
            r_state     <= S_WR;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load_data;
            r_state      <= S_RESP;
          end
        end
        S_WR: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Load/store unit that sits directly upstream of the word-addressed data memory, between the CPU execute stage and dataMemory. It accepts one RISC-V load or store request at a time: LB/LH/LW/LBU/LHU and SB/SH/SW. Sub-word stores are converted into read-modify-write sequences, because the memory only supports full-word writes. Load results are sign- or zero-extended, and misaligned or illegal accesses are flagged.

Parameters:
ADDR_WIDTH, 6, byte-address width; must match the data memory address port.
DATA_WIDTH, 32, word width; fixed at 32, other values unsupported.

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset_  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  unit can accept a request; high only in IDLE
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data; low byte or halfword used for SB/SH
resp_valid  output  1  one-cycle pulse; response complete
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  qualified by resp_valid; misaligned or illegal access
mem_addr  output  ADDR_WIDTH  to dataMemory address; always word-aligned, bits [1:0] = 00
mem_we  output  1  to dataMemory writeEnable
mem_wdata  output  32  to dataMemory writeData
mem_rdata  input  32  from dataMemory readData; combinational read of mem_addr

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; resp_err 0; mem_we 0; mem_wdata 0; mem_addr 0; request latches 0.
- Handshake and latching:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - On acceptance, addr, funct3, write and wdata are latched; inputs are ignored until the next IDLE.
- Legality:
  - Illegal: load funct3 in {011, 110, 111}; store funct3 not in {000, 001, 010}.
  - Misaligned: H/HU/SH with addr[0] = 1; W/SW with addr[1:0] != 00.
- Transitions from IDLE:
  - Illegal or misaligned: IDLE -> RESP; resp_err = 1, resp_rdata = 0, no memory write.
  - Loads: IDLE -> RD -> RESP.
  - SW: IDLE -> WR -> RESP.
  - SB/SH: IDLE -> RD -> WR -> RESP.
  - RESP -> IDLE unconditionally.
- Resulting latency from the accept edge to the resp_valid cycle: error 1 cycle; load 2; SW 2; SB/SH 3. req_ready returns high the cycle after RESP.
- RD state:
  - mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - At the end-of-cycle edge, mem_rdata is captured.
  - For loads it is extracted and extended into resp_rdata.
  - For SB/SH it is merged into a write buffer.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; halfword at addr[1] uses bits [16*addr[1]+15 : 16*addr[1]].
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- WR state:
  - mem_we = 1 for exactly one cycle; mem_addr is word-aligned.
  - SW: mem_wdata = wdata.
  - SB/SH: mem_wdata = captured word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
- mem_we = 0 in every state except WR.
- RESP state: resp_valid = 1 for one cycle; resp_err set accordingly. resp_rdata holds until the next response; there is no response backpressure.
- Reset mid-operation (reset_ low in RD or WR): state is forced to IDLE immediately and mem_we drops asynchronously. If reset_ falls before the WR edge, no memory write occurs. No response is issued for the aborted request.
- Back-to-back requests: a request held on req_valid during a busy period is accepted at the first edge in IDLE.

Test Plan:
1. Reset, then SW addr 8 data 0x12345678; LW addr 8 -> resp_rdata 0x12345678, resp_err 0. Check SW resp_valid 2 cycles after accept with exactly one mem_we pulse.
2. SB addr 9 data 0x000000AB, then LW addr 8 -> 0x1234AB78. Check SB latency of 3 cycles with mem_we high only in WR.
3. LB addr 9 -> 0xFFFFFFAB; LBU addr 9 -> 0x000000AB; LH addr 10 -> 0x00001234; LHU addr 8 -> 0x0000AB78.
4. SH addr 11 -> resp_err 1, resp_rdata 0, 1-cycle latency, no mem_we; LW addr 8 still 0x1234AB78. Also LW addr 6 -> err; funct3 011 -> err.
5. SH addr 14 data 0xBEEF on word 12 = 0 -> word 12 = 0xBEEF0000. Assert reset_ low during RD of SB addr 12 data 0xFF -> no write, word 12 unchanged, resp_valid 0, req_ready 1 after release.
6. Hold req_valid continuously across 16 alternating SW/LW to addresses 0..60 -> every LW returns the value just stored, and req_ready is low throughout each busy period.
